// File: rtl/md5_block_engine.sv
// MD5 compression engine: one 512-bit block through 64 steps, one step per clock.
// Shift amounts and K constants come from external combinational ROMs indexed by step_idx.
module md5_block_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] msg,
    output logic [5:0]   step_idx,
    input  logic [4:0]   shift_in,
    input  logic [31:0]  k_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] digest
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFinal = 2'd2;

    localparam logic [31:0] Iv0 = 32'h67452301;
    localparam logic [31:0] Iv1 = 32'hefcdab89;
    localparam logic [31:0] Iv2 = 32'h98badcfe;
    localparam logic [31:0] Iv3 = 32'h10325476;

    logic [1:0]   state_q, state_d;
    logic [5:0]   step_q, step_d;
    logic         done_q, done_d;
    logic [31:0]  h0_q, h0_d, h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
    logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [511:0] m_q, m_d;

    logic [1:0]   round;
    logic [3:0]   s4;
    logic [3:0]   g;
    logic [31:0]  f;
    logic [31:0]  m_word;
    logic [31:0]  t_sum;
    logic [63:0]  t_dup;
    logic [31:0]  t_rot;

    // Round function and message word schedule for the current step.
    always_comb begin
        round = step_q[5:4];
        s4    = step_q[3:0];
        f     = '0;
        g     = '0;
        unique case (round)
            2'd0: begin
                f = (b_q & c_q) | (~b_q & d_q);
                g = s4;
            end
            2'd1: begin
                f = (d_q & b_q) | (~d_q & c_q);
                g = s4 * 4'd5 + 4'd1;
            end
            2'd2: begin
                f = b_q ^ c_q ^ d_q;
                g = s4 * 4'd3 + 4'd5;
            end
            2'd3: begin
                f = c_q ^ (b_q | ~d_q);
                g = s4 * 4'd7;
            end
        endcase
    end

    assign m_word = m_q[{g, 5'd0} +: 32];
    assign t_sum  = a_q + f + k_in + m_word;
    // Rotate by shifting a doubled copy; the upper half holds rotl(t_sum, shift_in).
    assign t_dup  = {t_sum, t_sum} << shift_in;
    assign t_rot  = t_dup[63:32];

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        h0_d    = h0_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        h3_d    = h3_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        m_d     = m_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = msg;
                    step_d  = 6'd0;
                    state_d = StRun;
                    if (init) begin
                        a_d  = Iv0;
                        b_d  = Iv1;
                        c_d  = Iv2;
                        d_d  = Iv3;
                        h0_d = Iv0;
                        h1_d = Iv1;
                        h2_d = Iv2;
                        h3_d = Iv3;
                    end else begin
                        a_d = h0_q;
                        b_d = h1_q;
                        c_d = h2_q;
                        d_d = h3_q;
                    end
                end
            end
            StRun: begin
                a_d = d_q;
                d_d = c_q;
                c_d = b_q;
                b_d = b_q + t_rot;
                step_d = step_q + 6'd1;
                if (step_q == 6'd63) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                h0_d    = h0_q + a_q;
                h1_d    = h1_q + b_q;
                h2_d    = h2_q + c_q;
                h3_d    = h3_q + d_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 6'd0;
            done_q  <= 1'b0;
            h0_q    <= Iv0;
            h1_q    <= Iv1;
            h2_q    <= Iv2;
            h3_q    <= Iv3;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            h3_q    <= h3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            m_q     <= m_d;
        end
    end

    assign step_idx = (state_q == StRun) ? step_q : 6'd0;
    assign busy     = (state_q == StRun) || (state_q == StFinal);
    assign done     = done_q;
    assign digest   = {h3_q, h2_q, h1_q, h0_q};

endmodule

// File: tb/tb_md5_block_engine.sv
// Scoreboard bench for md5_block_engine: driver queues expected digests, monitor checks on done.
module tb_md5_block_engine;

    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int SHT [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    localparam logic [127:0] IV_D    = 128'h10325476_98badcfe_efcdab89_67452301;
    localparam logic [127:0] EMPTY_D = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] ABC_D   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic         start;
    logic         init;
    logic [511:0] msg;
    logic [5:0]   step_idx;
    logic [4:0]   shift_in;
    logic [31:0]  k_in;
    logic         busy;
    logic         done;
    logic [127:0] digest;

    typedef struct {
        logic [127:0] dig;
        int unsigned  cyc;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           n_push = 0;
    int           n_done = 0;
    logic [511:0] empty_msg;
    logic [511:0] abc_msg;

    md5_block_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .init     (init),
        .msg      (msg),
        .step_idx (step_idx),
        .shift_in (shift_in),
        .k_in     (k_in),
        .busy     (busy),
        .done     (done),
        .digest   (digest)
    );

    // Combinational ROM models.
    assign k_in     = KT[step_idx];
    assign shift_in = 5'(SHT[{step_idx[5:4], step_idx[1:0]}]);

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotl(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] md5_ref(logic [127:0] h, logic [511:0] m);
        logic [31:0] a, b, c, d, f, tmp;
        int g;
        a = h[31:0];
        b = h[63:32];
        c = h[95:64];
        d = h[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                f = (b & c) | (~b & d);
                g = i;
            end else if (i < 32) begin
                f = (d & b) | (~d & c);
                g = (5 * i + 1) % 16;
            end else if (i < 48) begin
                f = b ^ c ^ d;
                g = (3 * i + 5) % 16;
            end else begin
                f = c ^ (b | ~d);
                g = (7 * i) % 16;
            end
            tmp = d;
            d = c;
            c = b;
            b = b + rotl(a + f + KT[i] + m[32*g +: 32], SHT[(i / 16) * 4 + (i % 4)]);
            a = tmp;
        end
        return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1, want none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digest", digest, e.dig);
                chk("done_latency", 128'(cyc - e.cyc), 128'd65);
            end
        end
    end

    // Called mid-cycle; start is sampled on the next rising edge, then msg/init are scrambled.
    task automatic issue(logic [511:0] m, logic in, logic [127:0] exp, bit push);
        start = 1'b1;
        msg   = m;
        init  = in;
        @(posedge clk);
        #1;
        if (push) begin
            sb.push_back('{dig: exp, cyc: cyc});
            n_push++;
        end
        start = 1'b0;
        msg   = ~m;
        init  = ~in;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = (done === 1'b1);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done, want done within 200 cycles");
        end
    endtask

    task automatic chk_idle();
        @(posedge clk);
        #2;
        chk("busy_after_done", 128'(busy), 128'd0);
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b1;
        start  = 1'b0;
        init   = 1'b0;
        msg    = '0;
        empty_msg = '0;
        empty_msg[31:0] = 32'h00000080;
        abc_msg = '0;
        abc_msg[31:0] = 32'h80636261;
        abc_msg[14*32 +: 32] = 32'h00000018;

        // Asynchronous reset with the clock stopped.
        #3 rst_n = 1'b0;
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_step_idx", 128'(step_idx), 128'd0);
        chk("reset_digest", digest, IV_D);
        #2 clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Empty string, with step index sequence.
        issue(empty_msg, 1'b1, EMPTY_D, 1'b1);
        for (int i = 0; i < 64; i++) begin
            chk("step_idx_seq", 128'(step_idx), 128'(i));
            @(posedge clk);
            #1;
        end
        chk("final_step_idx", 128'(step_idx), 128'd0);
        chk("final_busy", 128'(busy), 128'd1);
        wait_done();
        chk_idle();

        // "abc" from IV.
        issue(abc_msg, 1'b1, ABC_D, 1'b1);
        wait_done();
        chk_idle();

        // Chaining: empty then "abc" with init=0, started back-to-back after done.
        issue(empty_msg, 1'b1, EMPTY_D, 1'b1);
        wait_done();
        issue(abc_msg, 1'b0, md5_ref(md5_ref(IV_D, empty_msg), abc_msg), 1'b1);
        wait_done();
        chk_idle();

        // start during RUN is ignored.
        issue(abc_msg, 1'b1, ABC_D, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        msg   = empty_msg;
        init  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_mid_run", 128'(busy), 128'd1);
        wait_done();
        repeat (80) @(posedge clk);
        #2;

        // Abort at step 30 by reset, then run "abc".
        issue(empty_msg, 1'b1, 128'd0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_step_idx_pre", 128'(step_idx), 128'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_step_idx", 128'(step_idx), 128'd0);
        chk("abort_digest", digest, IV_D);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #2;
        issue(abc_msg, 1'b1, ABC_D, 1'b1);
        wait_done();
        chk_idle();
        repeat (5) @(posedge clk);
        #2;

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        chk("done_count", 128'(n_done), 128'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
